// File: rtl/tetris_map_render.sv
// Tetris board store with collision port, line-clear FSM and VGA map layer.
// Optional cell grid overlay: define MAP_GRID_EN.
module tetris_map_render #(
  parameter int ORIGIN_X  = 240,
  parameter int ORIGIN_Y  = 80,
  parameter int CELL_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        wr_en,
  input  logic [3:0]  wr_col,
  input  logic [4:0]  wr_row,
  input  logic [2:0]  wr_color,
  input  logic [3:0]  rd_col,
  input  logic [4:0]  rd_row,
  output logic        rd_occ,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        clr_done,
  output logic [2:0]  clr_lines,
  output logic        MapDisplayEn,
  output logic [23:0] MapDisplayData
);

  localparam int COLS = 10;
  localparam int ROWS = 20;

  localparam logic [10:0] X0 = 11'(ORIGIN_X);
  localparam logic [10:0] X1 = 11'(ORIGIN_X + (COLS << CELL_LOG2));
  localparam logic [10:0] Y0 = 11'(ORIGIN_Y);
  localparam logic [10:0] Y1 = 11'(ORIGIN_Y + (ROWS << CELL_LOG2));

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SHIFT,
    DONE
  } state_t;

  state_t     state, stateNext;
  logic [4:0] rPtr, rNext;
  logic [4:0] sPtr, sNext;
  logic [2:0] cnt, cntNext;

  logic [2:0] board [ROWS][COLS];

  logic       wrOk;
  logic       rowFull;

  assign wrOk = (state == IDLE) && wr_en
             && (wr_col < 4'd10) && (wr_row < 5'd20);

  assign clr_busy = (state == SCAN) || (state == SHIFT);

  always_comb begin
    rowFull = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (board[rPtr][c] == 3'd0) rowFull = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rPtr  <= '0;
      sPtr  <= '0;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      rPtr  <= rNext;
      sPtr  <= sNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    rNext     = rPtr;
    sNext     = sPtr;
    cntNext   = cnt;
    unique case (state)
      IDLE: begin
        if (clr_start) begin
          stateNext = SCAN;
          rNext     = 5'd19;
          cntNext   = 3'd0;
        end
      end
      SCAN: begin
        if (rowFull) begin
          stateNext = SHIFT;
          sNext     = rPtr;
          cntNext   = cnt + 3'd1;
        end else if (rPtr == 5'd0) begin
          stateNext = DONE;
        end else begin
          rNext = rPtr - 5'd1;
        end
      end
      SHIFT: begin
        if (sPtr == 5'd0) stateNext = SCAN;
        else              sNext     = sPtr - 5'd1;
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Row shift walks upward; row 0 is blanked on the final step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          board[r][c] <= 3'd0;
        end
      end
    end else begin
      if (wrOk) board[wr_row][wr_col] <= wr_color;
      if (state == SHIFT) begin
        for (int c = 0; c < COLS; c++) begin
          if (sPtr == 5'd0) board[0][c]    <= 3'd0;
          else              board[sPtr][c] <= board[sPtr-5'd1][c];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_done  <= 1'b0;
      clr_lines <= 3'd0;
    end else begin
      clr_done <= (state == DONE);
      if (state == DONE) clr_lines <= cnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_occ <= 1'b0;
    end else if (rd_col >= 4'd10 || rd_row >= 5'd20) begin
      rd_occ <= 1'b1;
    end else begin
      rd_occ <= (board[rd_row][rd_col] != 3'd0);
    end
  end

  logic [10:0] px, py, dx, dy;
  logic        inBoard;
  logic        inS1;
  logic [3:0]  colS1;
  logic [4:0]  rowS1;

  assign px = {1'b0, pix_x};
  assign py = {1'b0, pix_y};
  assign dx = px - X0;
  assign dy = py - Y0;
  assign inBoard = (px >= X0) && (px < X1)
                && (py >= Y0) && (py < Y1);

`ifdef MAP_GRID_EN
  localparam logic [10:0] CMASK = 11'((1 << CELL_LOG2) - 1);
  logic gridS1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) gridS1 <= 1'b0;
    else      gridS1 <= ((dx & CMASK) == 11'd0)
                     || ((dy & CMASK) == 11'd0);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inS1  <= 1'b0;
      colS1 <= '0;
      rowS1 <= '0;
    end else begin
      inS1  <= inBoard;
      colS1 <= 4'(dx >> CELL_LOG2);
      rowS1 <= 5'(dy >> CELL_LOG2);
    end
  end

  logic [2:0]  code;
  logic [23:0] rgb;
  logic        enNext;
  logic [23:0] dataNext;

  always_comb begin
    code = 3'd0;
    if (inS1) code = board[rowS1][colS1];
  end

  always_comb begin
    case (code)
      3'd1:    rgb = 24'h00FFFF;
      3'd2:    rgb = 24'hFFFF00;
      3'd3:    rgb = 24'h800080;
      3'd4:    rgb = 24'h00FF00;
      3'd5:    rgb = 24'hFF0000;
      3'd6:    rgb = 24'h0000FF;
      3'd7:    rgb = 24'hFFA500;
      default: rgb = 24'h000000;
    endcase
  end

  always_comb begin
    enNext   = inS1 && (code != 3'd0);
    dataNext = enNext ? rgb : 24'h0;
`ifdef MAP_GRID_EN
    if (inS1 && gridS1) begin
      enNext   = 1'b1;
      dataNext = 24'h404040;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MapDisplayEn   <= 1'b0;
      MapDisplayData <= 24'h0;
    end else begin
      MapDisplayEn   <= enNext;
      MapDisplayData <= dataNext;
    end
  end

endmodule

// File: tb/tb_tetris_map_render.sv
// Directed bench for tetris_map_render (grid overlay off).
module tb_tetris_map_render;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_col = '0;
  logic [4:0]  wr_row = '0;
  logic [2:0]  wr_color = '0;
  logic [3:0]  rd_col = '0;
  logic [4:0]  rd_row = '0;
  logic        rd_occ;
  logic        clr_start = 1'b0;
  logic        clr_busy;
  logic        clr_done;
  logic [2:0]  clr_lines;
  logic        MapDisplayEn;
  logic [23:0] MapDisplayData;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  tetris_map_render dut (
    .clk            (clk),
    .rst            (rst),
    .pix_x          (pix_x),
    .pix_y          (pix_y),
    .wr_en          (wr_en),
    .wr_col         (wr_col),
    .wr_row         (wr_row),
    .wr_color       (wr_color),
    .rd_col         (rd_col),
    .rd_row         (rd_row),
    .rd_occ         (rd_occ),
    .clr_start      (clr_start),
    .clr_busy       (clr_busy),
    .clr_done       (clr_done),
    .clr_lines      (clr_lines),
    .MapDisplayEn   (MapDisplayEn),
    .MapDisplayData (MapDisplayData)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int c, input int r, input int color);
    wr_en    = 1'b1;
    wr_col   = 4'(c);
    wr_row   = 5'(r);
    wr_color = 3'(color);
    tick();
    wr_en    = 1'b0;
  endtask

  task automatic rdq(input int c, input int r, output logic occ);
    rd_col = 4'(c);
    rd_row = 5'(r);
    tick();
    occ = rd_occ;
  endtask

  task automatic px(input int x, input int y,
                    output logic en, output logic [23:0] data);
    pix_x = 10'(x);
    pix_y = 10'(y);
    tick();
    tick();
    en   = MapDisplayEn;
    data = MapDisplayData;
  endtask

  task automatic countOcc(output int n);
    n = 0;
    for (int r = 0; r < 20; r++) begin
      for (int c = 0; c < 10; c++) begin
        rd_col = 4'(c);
        rd_row = 5'(r);
        tick();
        if (rd_occ) n++;
      end
    end
  endtask

  task automatic waitDone(input int bound, output int n);
    n = 0;
    while (n < bound) begin
      tick();
      n++;
      if (clr_done) break;
    end
  endtask

  task automatic doReset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    logic        occ;
    logic        en;
    logic [23:0] data;
    int          n;

    rd_col = 4'd10;
    tick();
    tick();
    chk("rst_rd_occ", rd_occ, 0);
    chk("rst_busy", clr_busy, 0);
    chk("rst_done", clr_done, 0);
    chk("rst_lines", clr_lines, 0);
    chk("rst_en", MapDisplayEn, 0);
    chk("rst_data", MapDisplayData, 0);
    rst = 1'b1;
    tick();

    wr(3, 19, 5);
    px(288, 384, en, data);
    chk("pix_red_en", en, 1);
    chk("pix_red_data", data, 24'hFF0000);
    px(100, 50, en, data);
    chk("outside_en", en, 0);
    chk("outside_data", data, 0);
    px(240, 80, en, data);
    chk("empty_en", en, 0);
    chk("empty_data", data, 0);

    wr(9, 0, 7);
    wr(0, 19, 6);
    px(399, 80, en, data);
    chk("xlast_data", data, 24'hFFA500);
    px(400, 80, en, data);
    chk("xend_en", en, 0);
    px(239, 80, en, data);
    chk("xpre_en", en, 0);
    px(240, 399, en, data);
    chk("ylast_data", data, 24'h0000FF);
    px(240, 400, en, data);
    chk("yend_en", en, 0);
    px(240, 79, en, data);
    chk("ypre_en", en, 0);

    rdq(10, 0, occ);
    chk("rd_col10", occ, 1);
    rdq(0, 20, occ);
    chk("rd_row20", occ, 1);
    rdq(3, 19, occ);
    chk("rd_set", occ, 1);
    rdq(4, 19, occ);
    chk("rd_empty", occ, 0);

    // pass over a board with no full rows
    doReset();
    wr(2, 19, 3);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    chk("scan_busy", clr_busy, 1);
    waitDone(100, n);
    chk("nofull_latency", n, 21);
    chk("nofull_lines", clr_lines, 0);
    chk("nofull_idle", clr_busy, 0);
    tick();
    chk("done_pulse", clr_done, 0);

    // two full rows, last write shares the cycle with clr_start
    doReset();
    for (int c = 0; c < 10; c++) begin
      wr(c, 18, (c % 7) + 1);
      wr(c, 19, ((c + 3) % 7) + 1);
    end
    wr_en     = 1'b1;
    wr_col    = 4'd0;
    wr_row    = 5'd17;
    wr_color  = 3'd2;
    clr_start = 1'b1;
    tick();
    wr_en     = 1'b0;
    clr_start = 1'b0;
    tick();
    tick();
    tick();
    wr_en     = 1'b1;
    wr_col    = 4'd5;
    wr_row    = 5'd5;
    wr_color  = 3'd3;
    clr_start = 1'b1;
    tick();
    wr_en     = 1'b0;
    clr_start = 1'b0;
    chk("busy_mid", clr_busy, 1);
    waitDone(300, n);
    chk("two_done_seen", clr_done, 1);
    chk("two_lines", clr_lines, 2);
    tick();
    chk("no_second_busy", clr_busy, 0);
    tick();
    chk("no_second_busy2", clr_busy, 0);
    rdq(0, 19, occ);
    chk("shift_cell_0_19", occ, 1);
    rdq(5, 5, occ);
    chk("drop_write", occ, 0);
    px(245, 390, en, data);
    chk("shift_color", data, 24'hFFFF00);
    countOcc(n);
    chk("two_occ_total", n, 1);

    // async reset while in SHIFT
    for (int c = 1; c < 10; c++) wr(c, 19, c % 7 + 1);
    pix_x     = 10'd240;
    pix_y     = 10'd384;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    tick();
    chk("shift_busy", clr_busy, 1);
    chk("shift_en", MapDisplayEn, 1);
    rst = 1'b0;
    #1;
    chk("arst_busy", clr_busy, 0);
    chk("arst_lines", clr_lines, 0);
    chk("arst_done", clr_done, 0);
    chk("arst_en", MapDisplayEn, 0);
    chk("arst_data", MapDisplayData, 0);
    chk("arst_occ", rd_occ, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("arst_idle", clr_busy, 0);
    countOcc(n);
    chk("arst_board", n, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/tetris_map_render.md
TETRIS_MAP_RENDER -- requirements
Module: tetris_map_render

Interface
REQ-001 Parameter ORIGIN_X, default 240, pixel x of the board's left edge.
REQ-002 Parameter ORIGIN_Y, default 80, pixel y of the board's top edge.
REQ-003 Parameter CELL_LOG2, default 4, log2 of the cell size in pixels (16 px cells).
REQ-004 clk  input  1  sole clock, all state on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 pix_x  input  10  current pixel column from the VGA timing block.
REQ-007 pix_y  input  10  current pixel row from the VGA timing block.
REQ-008 wr_en  input  1  write one board cell this cycle.
REQ-009 wr_col  input  4  cell column of the write, 0..9.
REQ-010 wr_row  input  5  cell row of the write, 0..19, 0 = top.
REQ-011 wr_color  input  3  colour code of the write, 0 = empty.
REQ-012 rd_col  input  4  collision-query column.
REQ-013 rd_row  input  5  collision-query row.
REQ-014 rd_occ  output  1  collision-query result.
REQ-015 clr_start  input  1  request a full-line clear pass.
REQ-016 clr_busy  output  1  clear pass in progress.
REQ-017 clr_done  output  1  one-cycle pulse at the end of a pass.
REQ-018 clr_lines  output  3  lines removed by the last pass, 0..4.
REQ-019 MapDisplayEn  output  1  map layer owns the pixel (feeds the display priority mux).
REQ-020 MapDisplayData  output  24  RGB888 of the map pixel.

Function
REQ-021 Board storage SHALL be 10 columns x 20 rows of 3-bit colour codes.
REQ-022 wr_en SHALL write wr_color into the addressed cell at the clock edge only when the FSM is in IDLE and wr_col<10 and wr_row<20; otherwise the write is dropped.
REQ-023 rd_occ SHALL be registered with 1-cycle latency: 1 if the cell is non-zero, or if rd_col>=10 or rd_row>=20 (out of range counts as wall).
REQ-024 The pixel path SHALL be a 2-stage pipeline: stage 1 registers the in-board flag and cell column/row, computed as (pix-ORIGIN)>>CELL_LOG2; stage 2 registers the outputs.
REQ-025 In-board SHALL mean ORIGIN_X<=pix_x<ORIGIN_X+(10<<CELL_LOG2) and ORIGIN_Y<=pix_y<ORIGIN_Y+(20<<CELL_LOG2).
REQ-026 Outside the board, or on an empty cell, MapDisplayEn SHALL be 0 and MapDisplayData SHALL be 0.
REQ-027 Palette for codes 1..7: 00FFFF, FFFF00, 800080, 00FF00, FF0000, 0000FF, FFA500.
REQ-028 The pixel path SHALL keep running during clear passes and display the board as it is at that moment.
REQ-029 The FSM SHALL have the states IDLE, SCAN, SHIFT and DONE; clr_busy=1 in SCAN and SHIFT.
REQ-030 IDLE: clr_start=1 -> SCAN with row pointer r=19 and line count=0; a write in the same cycle commits first and is seen by the scan.
REQ-031 SCAN: if row r is full (all 10 cells non-zero) -> SHIFT with s=r and count+1; else if r=0 -> DONE; else r-1.
REQ-032 SHIFT: copy row[s-1] into row[s] and decrement s, one row per cycle; when s=0, clear row 0 and return to SCAN with r unchanged (the same row is rechecked).
REQ-033 DONE: load clr_lines with the count, pulse clr_done for 1 cycle, then go to IDLE.
REQ-034 clr_start SHALL be ignored outside IDLE.

Reset
REQ-035 rst=0 SHALL asynchronously clear all cells to 0, set the FSM to IDLE, and drive rd_occ, clr_busy, clr_done, clr_lines, MapDisplayEn and MapDisplayData to 0, including mid-pass; the pipeline registers SHALL also clear.

Configuration
REQ-036 Macro MAP_GRID_EN defined: in-board pixels whose offset within the cell is 0 in x or y SHALL output MapDisplayEn=1 with 404040, overriding the cell colour.
REQ-037 Macro MAP_GRID_EN undefined: no grid; REQ-026 and REQ-027 apply unchanged.

Verification
REQ-038 Write (3,19,code 5), then pix=(288,384) -> 2 cycles later MapDisplayEn=1, MapDisplayData=FF0000 (grid off).
REQ-039 pix=(100,50) or empty cell -> MapDisplayEn=0, MapDisplayData=0; rd_col=10 -> rd_occ=1 next cycle.
REQ-040 Rows 18 and 19 full, cell (0,17)=2, clr_start -> clr_done pulse, clr_lines=2, cell (0,19)=2, rows 0..18 empty.
REQ-041 No full rows, clr_start -> clr_done exactly 21 cycles after the clr_start edge (20 SCAN cycles + DONE), clr_lines=0.
REQ-042 wr_en and clr_start asserted during clr_busy -> the write is dropped and no second pass starts; rst=0 asserted in SHIFT -> all outputs 0, board empty, IDLE.
